wb_mem_arbiter: RTL and testbench

//  Single-clock Wishbone arbiter/decoder between the two bus masters (m0 = Z80 CPU, m1 = video fetch)
//  and the two memory slaves (s0 = SDRAM controller, s1 = boot ROM). It sits directly upstream of the

---
 rtl/wb_sys_pkg.sv | 24 ++
 rtl/wb_addr_decode.sv | 17 +
 rtl/wb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sys_pkg.sv
// Shared types for the memory-side Wishbone arbiter: FSM encoding, master request bundle
// and the fill byte returned on an aborted cycle.
package wb_sys_pkg;

   localparam int WB_AW = 24;
   localparam int WB_DW = 8;
   localparam logic [WB_DW-1:0] ROM_FILL = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      GNT_M0,
      GNT_M1,
      ABORT
   } arb_state_t;

   typedef struct packed {
      logic             cyc;
      logic             stb;
      logic             we;
      logic [WB_AW-1:0] adr;
      logic [WB_DW-1:0] dat;
   } wb_req_t;

endpackage

// File: rtl/wb_addr_decode.sv
// Boot-ROM overlay decode: a read inside the low ROM window while the overlay is on goes to
// the ROM, everything else (including writes under the ROM) goes to SDRAM.
module wb_addr_decode #(
   parameter int AW     = 24,
   parameter int ROM_AW = 14
) (
   input  logic [AW-1:0] adr,
   input  logic          we,
   input  logic          boot_rom_en,
   output logic          rom_hit
);

   always_comb begin
      rom_hit = boot_rom_en & ~we & (adr[AW-1:ROM_AW] == '0);
   end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master / two-slave Wishbone arbiter with boot-ROM overlay and bounded video run length.
// Optional stalled-cycle abort is built when WB_ARB_TIMEOUT_EN is defined.
//
//   state  | meaning
//   IDLE   | no grant; arbitrate pending requests
//   GNT_M0 | CPU owns the slaves until it drops cyc
//   GNT_M1 | video owns the slaves until it drops cyc
//   ABORT  | one cycle: stalled cycle terminated with fill data (timeout build only)
module wb_mem_arbiter
   import wb_sys_pkg::*;
#(
   parameter int AW          = WB_AW,
   parameter int DW          = WB_DW,
   parameter int ROM_AW      = 14,
   parameter int MAX_VID_RUN = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   input  logic          m0_we_i,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [DW-1:0] m0_dat_i,
   output logic [DW-1:0] m0_dat_o,
   output logic          m0_ack_o,
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   input  logic          m1_we_i,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [DW-1:0] m1_dat_i,
   output logic [DW-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic          s0_cyc_o,
   output logic          s0_stb_o,
   output logic          s0_we_o,
   output logic [AW-1:0] s0_adr_o,
   output logic [DW-1:0] s0_dat_o,
   input  logic [DW-1:0] s0_dat_i,
   input  logic          s0_ack_i,
   output logic          s1_cyc_o,
   output logic          s1_stb_o,
   output logic [AW-1:0] s1_adr_o,
   input  logic [DW-1:0] s1_dat_i,
   input  logic          s1_ack_i,
   input  logic          boot_rom_en,
   output logic [1:0]    gnt_o,
   output logic          timeout_err_o
);

   localparam int               RUN_W   = $clog2(MAX_VID_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_VID_RUN);

   // The request bundle is sized by the package, so the ports must match it.
   if (AW != WB_AW || DW != WB_DW || TIMEOUT_CYC < 1 || MAX_VID_RUN < 1) begin : g_param_chk
      $error("wb_mem_arbiter: unsupported parameter set");
   end

   arb_state_t       state_q, state_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             sel_q, sel_d;
   logic             sel_vld_q, sel_vld_d;
   logic [DW-1:0]    m0_dat_q, m0_dat_d;
   logic [DW-1:0]    m1_dat_q, m1_dat_d;

   logic             req_m0, req_m1;
   logic             granted, gnt_m1;
   wb_req_t          mreq;
   logic             eff_we, rom_hit, sel_rom;
   logic             slv_ack, ack_ok;
   logic [DW-1:0]    slv_dat;

   assign req_m0 = m0_cyc_i & m0_stb_i;
   assign req_m1 = m1_cyc_i & m1_stb_i;

   always_comb begin
      granted = (state_q == GNT_M0) || (state_q == GNT_M1);
      gnt_m1  = (state_q == GNT_M1);
      if (gnt_m1) begin
         mreq = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i, adr: m1_adr_i, dat: m1_dat_i};
      end else begin
         mreq = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i, adr: m0_adr_i, dat: m0_dat_i};
      end
      // Video is read-only: its we never reaches the decode or the SDRAM.
      eff_we = mreq.we & ~gnt_m1;
   end

   wb_addr_decode #(
      .AW     (AW),
      .ROM_AW (ROM_AW)
   ) u_decode (
      .adr         (mreq.adr),
      .we          (eff_we),
      .boot_rom_en (boot_rom_en),
      .rom_hit     (rom_hit)
   );

   // Once a strobe has been presented, its slave stays fixed until that strobe is acked.
   always_comb begin
      sel_rom = sel_vld_q ? sel_q : rom_hit;
      slv_ack = sel_rom ? s1_ack_i : s0_ack_i;
      slv_dat = sel_rom ? s1_dat_i : s0_dat_i;
      ack_ok  = granted & mreq.cyc & mreq.stb & slv_ack;
   end

   assign s0_cyc_o = granted & ~sel_rom & mreq.cyc;
   assign s0_stb_o = granted & ~sel_rom & mreq.stb;
   assign s0_we_o  = granted & ~sel_rom & eff_we;
   assign s0_adr_o = mreq.adr;
   assign s0_dat_o = mreq.dat;
   assign s1_cyc_o = granted & sel_rom & mreq.cyc;
   assign s1_stb_o = granted & sel_rom & mreq.stb;
   assign s1_adr_o = mreq.adr;

   assign gnt_o    = {state_q == GNT_M1, state_q == GNT_M0};
   assign m0_dat_o = m0_dat_q;
   assign m1_dat_o = m1_dat_q;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             abort_m1_q, abort_m1_d;
   logic             stall;

   always_comb begin
      stall = granted & mreq.cyc & mreq.stb & ~slv_ack;
      tmo_d = (stall && tmo_q != '0) ? tmo_q - 1'b1 : TMO_LOAD;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q      <= TMO_LOAD;
         abort_m1_q <= 1'b0;
      end else begin
         tmo_q      <= tmo_d;
         abort_m1_q <= abort_m1_d;
      end
   end

   assign timeout_err_o = (state_q == ABORT);
   assign m0_ack_o      = (ack_ok & ~gnt_m1) | ((state_q == ABORT) & ~abort_m1_q);
   assign m1_ack_o      = (ack_ok &  gnt_m1) | ((state_q == ABORT) &  abort_m1_q);
`else
   assign timeout_err_o = 1'b0;
   assign m0_ack_o      = ack_ok & ~gnt_m1;
   assign m1_ack_o      = ack_ok &  gnt_m1;
`endif

   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      sel_d     = sel_rom;
      sel_vld_d = 1'b0;
      m0_dat_d  = m0_dat_q;
      m1_dat_d  = m1_dat_q;
`ifdef WB_ARB_TIMEOUT_EN
      abort_m1_d = abort_m1_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_m1 && (run_q < RUN_MAX || !req_m0)) begin
               state_d = GNT_M1;
               if (req_m0) begin
                  run_d = run_q + 1'b1;
               end
            end else if (req_m0) begin
               state_d = GNT_M0;
               run_d   = '0;
            end
         end
         GNT_M0, GNT_M1: begin
            if (!mreq.cyc) begin
               state_d = IDLE;
            end
`ifdef WB_ARB_TIMEOUT_EN
            else if (stall && tmo_q == '0) begin
               state_d    = ABORT;
               abort_m1_d = gnt_m1;
               if (gnt_m1) begin
                  m1_dat_d = ROM_FILL;
               end else begin
                  m0_dat_d = ROM_FILL;
               end
            end
`endif
            else begin
               sel_vld_d = mreq.stb & ~slv_ack;
            end
         end
         default: state_d = IDLE;
      endcase
      if (ack_ok) begin
         if (gnt_m1) begin
            m1_dat_d = slv_dat;
         end else begin
            m0_dat_d = slv_dat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         run_q     <= '0;
         sel_q     <= 1'b0;
         sel_vld_q <= 1'b0;
         m0_dat_q  <= '0;
         m1_dat_q  <= '0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         sel_q     <= sel_d;
         sel_vld_q <= sel_vld_d;
         m0_dat_q  <= m0_dat_d;
         m1_dat_q  <= m1_dat_d;
      end
   end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed scenarios plus randomized single-master
// transfers scored against a behavioural routing/memory model.
`timescale 1ns/1ps
module tb_wb_mem_arbiter;

   localparam int AW          = 24;
   localparam int DW          = 8;
   localparam int ROM_AW      = 14;
   localparam int MAX_VID_RUN = 4;
   localparam int TIMEOUT_CYC = 16;
   localparam logic [AW-1:0] ROM_SIZE = AW'(1 << ROM_AW);

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_cyc_i, m0_stb_i, m0_we_i, m0_ack_o;
   logic [AW-1:0] m0_adr_i;
   logic [DW-1:0] m0_dat_i, m0_dat_o;
   logic          m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o;
   logic [AW-1:0] m1_adr_i;
   logic [DW-1:0] m1_dat_i, m1_dat_o;
   logic          s0_cyc_o, s0_stb_o, s0_we_o, s0_ack_i;
   logic [AW-1:0] s0_adr_o;
   logic [DW-1:0] s0_dat_o, s0_dat_i;
   logic          s1_cyc_o, s1_stb_o, s1_ack_i;
   logic [AW-1:0] s1_adr_o;
   logic [DW-1:0] s1_dat_i;
   logic          boot_rom_en;
   logic [1:0]    gnt_o;
   logic          timeout_err_o;

   always #5 clk = ~clk;

   wb_mem_arbiter #(
      .AW(AW), .DW(DW), .ROM_AW(ROM_AW), .MAX_VID_RUN(MAX_VID_RUN), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
      .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
      .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .s0_cyc_o(s0_cyc_o), .s0_stb_o(s0_stb_o), .s0_we_o(s0_we_o), .s0_adr_o(s0_adr_o),
      .s0_dat_o(s0_dat_o), .s0_dat_i(s0_dat_i), .s0_ack_i(s0_ack_i),
      .s1_cyc_o(s1_cyc_o), .s1_stb_o(s1_stb_o), .s1_adr_o(s1_adr_o),
      .s1_dat_i(s1_dat_i), .s1_ack_i(s1_ack_i),
      .boot_rom_en(boot_rom_en), .gnt_o(gnt_o), .timeout_err_o(timeout_err_o)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [DW-1:0] sdram_mem [256];
   logic [DW-1:0] ref_mem   [256];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
      return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h3F;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_m(input bit m, input bit cyc, input bit we,
                          input logic [AW-1:0] adr, input logic [DW-1:0] wd);
      if (m) begin
         m1_cyc_i = cyc; m1_stb_i = cyc; m1_we_i = we; m1_adr_i = adr; m1_dat_i = wd;
      end else begin
         m0_cyc_i = cyc; m0_stb_i = cyc; m0_we_i = we; m0_adr_i = adr; m0_dat_i = wd;
      end
   endtask

   task automatic slaves_quiet;
      s0_ack_i = 1'b0; s1_ack_i = 1'b0;
      s0_dat_i = DW'($urandom); s1_dat_i = DW'($urandom);
   endtask

   // One complete single-master transfer; expectations come from the overlay rules and ref_mem.
   task automatic xfer(input bit m, input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                       input bit rom_en, input int lat, input bit flip);
      bit            to_rom;
      logic [DW-1:0] exp_rd;
      to_rom = rom_en && !(we && !m) && (adr < ROM_SIZE);
      exp_rd = to_rom ? rom_val(adr) : ref_mem[adr[7:0]];
      boot_rom_en = rom_en;
      drive_m(m, 1'b1, we, adr, wd);
      #1;
      check("arb_latency", 32'(s0_stb_o | s1_stb_o), 0);
      tick;
      check("gnt", 32'(gnt_o), m ? 2 : 1);
      check("s1_stb", 32'(s1_stb_o), 32'(to_rom));
      check("s0_stb", 32'(s0_stb_o), 32'(!to_rom));
      check("s_adr", 32'(to_rom ? s1_adr_o : s0_adr_o), 32'(adr));
      if (!to_rom) check("s0_we", 32'(s0_we_o), 32'(we && !m));
      if (!to_rom && we && !m) check("s0_dat", 32'(s0_dat_o), 32'(wd));
      for (int i = 0; i < lat; i++) begin
         check("early_ack", 32'(m0_ack_o | m1_ack_o), 0);
         tick;
         if (flip && i == 0) boot_rom_en = !rom_en;
         #1;
         check("sel_held", 32'(s1_stb_o), 32'(to_rom));
      end
      if (to_rom) begin
         s1_ack_i = 1'b1; s1_dat_i = rom_val(s1_adr_o);
      end else begin
         s0_ack_i = 1'b1; s0_dat_i = sdram_mem[s0_adr_o[7:0]];
         if (s0_we_o) sdram_mem[s0_adr_o[7:0]] = s0_dat_o;
      end
      #1;
      check("ack_mine", 32'(m ? m1_ack_o : m0_ack_o), 1);
      check("ack_other", 32'(m ? m0_ack_o : m1_ack_o), 0);
      tick;
      drive_m(m, 1'b0, 1'b0, '0, '0);
      slaves_quiet();
      #1;
      check("rd_dat", 32'(m ? m1_dat_o : m0_dat_o), 32'(exp_rd));
      tick;
      check("idle_gnt", 32'(gnt_o), 0);
      if (!m && we && !to_rom) ref_mem[adr[7:0]] = wd;
      boot_rom_en = rom_en;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int run;
      int exp_g;
      for (int i = 0; i < 256; i++) begin
         sdram_mem[i] = DW'(i * 7 + 1);
         ref_mem[i]   = DW'(i * 7 + 1);
      end
      rst = 1'b1; boot_rom_en = 1'b0;
      drive_m(1'b0, 1'b0, 1'b0, '0, '0);
      drive_m(1'b1, 1'b0, 1'b0, '0, '0);
      slaves_quiet();
      tick; tick;
      check("rst_gnt", 32'(gnt_o), 0);
      check("rst_stb", 32'({s0_stb_o, s1_stb_o, s0_cyc_o, s1_cyc_o}), 0);
      check("rst_ack", 32'({m0_ack_o, m1_ack_o}), 0);
      check("rst_dat", 32'({m0_dat_o, m1_dat_o}), 0);
      check("rst_err", 32'(timeout_err_o), 0);
      rst = 1'b0;
      tick;

      // ROM read, write-under-ROM, video write forced to read
      xfer(1'b0, 1'b0, 24'h000100, 8'h00, 1'b1, 1, 1'b0);
      check("rom_read_3e", 32'(m0_dat_o), 32'h3E);
      xfer(1'b0, 1'b1, 24'h000100, 8'hA5, 1'b1, 1, 1'b0);
      xfer(1'b1, 1'b1, 24'h004000, 8'h77, 1'b0, 2, 1'b0);

      // Contention: video may run MAX_VID_RUN times while the CPU waits
      boot_rom_en = 1'b0;
      run = 0;
      for (int k = 0; k < 10; k++) begin
         drive_m(1'b0, 1'b1, 1'b0, 24'h000200, '0);
         drive_m(1'b1, 1'b1, 1'b0, 24'h004010, '0);
         if (run < MAX_VID_RUN) begin
            exp_g = 2; run = run + 1;
         end else begin
            exp_g = 1; run = 0;
         end
         tick;
         check("contend_gnt", 32'(gnt_o), exp_g);
         s0_ack_i = 1'b1;
         #1;
         check("contend_ack", 32'({m1_ack_o, m0_ack_o}), exp_g);
         tick;
         drive_m(exp_g == 2, 1'b0, 1'b0, '0, '0);
         slaves_quiet();
         tick;
         check("contend_bubble", 32'(gnt_o), 0);
      end
      drive_m(1'b0, 1'b0, 1'b0, '0, '0);
      drive_m(1'b1, 1'b0, 1'b0, '0, '0);
      tick;

      // Stalled SDRAM cycle
      drive_m(1'b0, 1'b1, 1'b0, 24'h000300, '0);
      tick;
`ifdef WB_ARB_TIMEOUT_EN
      repeat (TIMEOUT_CYC - 1) tick;
      check("tmo_pre_ack", 32'(m0_ack_o), 0);
      check("tmo_pre_stb", 32'(s0_stb_o), 1);
      tick;
      check("tmo_ack", 32'(m0_ack_o), 1);
      check("tmo_dat", 32'(m0_dat_o), 32'hFF);
      check("tmo_err", 32'(timeout_err_o), 1);
      check("tmo_gnt", 32'(gnt_o), 0);
      check("tmo_stb", 32'(s0_stb_o | s0_cyc_o), 0);
      drive_m(1'b0, 1'b0, 1'b0, '0, '0);
      tick;
      check("tmo_err_pulse", 32'(timeout_err_o), 0);
      check("tmo_ack_drop", 32'(m0_ack_o), 0);
`else
      repeat (40) tick;
      check("stall_no_ack", 32'(m0_ack_o), 0);
      check("stall_stb", 32'(s0_stb_o), 1);
      check("stall_no_err", 32'(timeout_err_o), 0);
      s0_ack_i = 1'b1; s0_dat_i = sdram_mem[8'h00];
      tick;
      drive_m(1'b0, 1'b0, 1'b0, '0, '0);
      slaves_quiet();
      tick;
`endif
      tick;

      // Reset in the middle of an SDRAM write
      drive_m(1'b0, 1'b1, 1'b1, 24'h000500, 8'h5C);
      tick;
      check("pre_rst_stb", 32'(s0_stb_o), 1);
      rst = 1'b1;
      tick;
      check("rst_mid_stb", 32'({s0_stb_o, s1_stb_o}), 0);
      check("rst_mid_gnt", 32'(gnt_o), 0);
      check("rst_mid_ack", 32'({m0_ack_o, m1_ack_o}), 0);
      rst = 1'b0;
      drive_m(1'b0, 1'b0, 1'b0, '0, '0);
      s0_ack_i = 1'b1;
      #1;
      check("stale_ack", 32'(m0_ack_o), 0);
      tick;
      check("stale_gnt", 32'(gnt_o), 0);
      slaves_quiet();
      tick;

      // Randomized single-master transfers
      for (int n = 0; n < 80; n++) begin
         bit            m, we, rom_en, flip;
         logic [AW-1:0] adr;
         int            region, lat;
         m      = 1'($urandom_range(0, 1));
         we     = 1'($urandom_range(0, 1));
         rom_en = 1'($urandom_range(0, 1));
         flip   = 1'($urandom_range(0, 1));
         lat    = $urandom_range(0, 3);
         region = $urandom_range(0, 2);
         adr    = AW'($urandom);
         if (region == 0) adr = adr & (ROM_SIZE - 1);
         if (region == 1) adr = (adr & (ROM_SIZE - 1)) | ROM_SIZE;
         adr[7:0] = 8'($urandom_range(0, 15));
         if (m && we) adr[ROM_AW] = 1'b1;
         xfer(m, we, adr, DW'($urandom), rom_en, lat, flip);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
